// File: rtl/n64_poll_transmitter.sv
// n64_poll_transmitter
//   Sends one console command byte plus a stop bit onto the open-drain N64
//   controller bus. The block never drives the line high. It only requests a
//   pull-low; the pad and tristate sit outside this module. Bits go out MSB
//   first, each in a 4 us cell:
//     '0' = 3 us low, then 1 us released
//     '1' = 1 us low, then 3 us released
//     stop = 1 us low, then released
//   A frame occupies 33 us. The `done` pulse marks the moment the line is
//   released, and it arms the downstream reader.
//
// Parameters
//   CLK_PER_US   clock cycles per microsecond (2..1365)
//   POLL_PERIOD  autopoll interval in cycles (only with N64_TX_AUTOPOLL_EN)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      frame request, sampled only while idle
//   cmd[7:0]   command byte, captured when start is accepted
//   drive_low  1 = pull bus low, 0 = release
//   busy       high from the cycle after acceptance until done
//   done       one-cycle pulse at end of frame
//
// Build option
//   N64_TX_AUTOPOLL_EN  when defined, a free-running period counter issues a
//                       poll (cmd 0x01) every POLL_PERIOD cycles. External
//                       start takes priority over a pending poll.
module n64_poll_transmitter #(
  parameter int unsigned CLK_PER_US  = 100
`ifdef N64_TX_AUTOPOLL_EN
  , parameter int unsigned POLL_PERIOD = 1666667
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  output logic       drive_low,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW
  } state_t;

  // Phase reload values: a phase of N cycles loads N-1 and expires at 0.
  localparam logic [11:0] LEN1 = 12'(CLK_PER_US - 1);
  localparam logic [11:0] LEN3 = 12'(3 * CLK_PER_US - 1);

  state_t      state_q,     state_d;
  logic [2:0]  bit_q,       bit_d;
  logic [7:0]  shift_q,     shift_d;
  logic [11:0] phase_q,     phase_d;
  logic        drive_low_q, drive_low_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic        launch;
  logic [7:0]  launch_cmd;
  logic        phase_end;

`ifdef N64_TX_AUTOPOLL_EN
  localparam logic [20:0] PERIOD_LAST = 21'(POLL_PERIOD - 1);

  logic [20:0] period_q, period_d;
  logic        pending_q, pending_d;
  logic        poll_tick;

  always_comb begin
    poll_tick = (period_q == PERIOD_LAST);
    period_d  = poll_tick ? '0 : period_q + 21'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      pending_q <= pending_d;
    end
  end
`endif

  assign phase_end = (phase_q == '0);

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    done_d     = 1'b0;
    launch     = 1'b0;
    launch_cmd = cmd;
`ifdef N64_TX_AUTOPOLL_EN
    // Ticks arriving while a request is already pending or a frame is in
    // flight merge into the single pending flag.
    pending_d  = pending_q | poll_tick;
`endif

    if (state_q == IDLE) begin
      if (start) begin
        launch     = 1'b1;
        launch_cmd = cmd;
`ifdef N64_TX_AUTOPOLL_EN
        pending_d  = 1'b0;
`endif
      end
`ifdef N64_TX_AUTOPOLL_EN
      else if (pending_q) begin
        launch     = 1'b1;
        launch_cmd = 8'h01;
        pending_d  = 1'b0;
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          shift_d = launch_cmd;
          bit_d   = 3'd7;
          phase_d = launch_cmd[7] ? LEN1 : LEN3;
          state_d = BIT_LOW;
        end
      end
      BIT_LOW: begin
        if (phase_end) begin
          phase_d = shift_q[7] ? LEN3 : LEN1;
          state_d = BIT_HIGH;
        end else begin
          phase_d = phase_q - 12'd1;
        end
      end
      BIT_HIGH: begin
        if (phase_end) begin
          if (bit_q == '0) begin
            phase_d = LEN1;
            state_d = STOP_LOW;
          end else begin
            // The next bit sits in shift_q[6] until the shift lands, so its
            // low length is chosen from there.
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            phase_d = shift_q[6] ? LEN1 : LEN3;
            state_d = BIT_LOW;
          end
        end else begin
          phase_d = phase_q - 12'd1;
        end
      end
      STOP_LOW: begin
        if (phase_end) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q - 12'd1;
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state, so they change cleanly on
    // the same edge as the state itself.
    drive_low_d = (state_d == BIT_LOW) || (state_d == STOP_LOW);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      phase_q     <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign drive_low = drive_low_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
